// File: rtl/wb_ram_arb2.sv
// Two-master Wishbone arbiter in front of a single RAM slave: round-robin
// grant held for the whole cycle, plus a no-response watchdog.
`timescale 1ns/1ps
module wb_ram_arb2 #(
  parameter int aw      = 25,
  parameter int dw      = 32,
  parameter int timeout = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic [2*aw-1:0]   m_adr_i,
  input  logic [3:0]        m_bte_i,
  input  logic [5:0]        m_cti_i,
  input  logic [1:0]        m_cyc_i,
  input  logic [1:0]        m_stb_i,
  input  logic [1:0]        m_we_i,
  input  logic [7:0]        m_sel_i,
  input  logic [2*dw-1:0]   m_dat_i,
  output logic [dw-1:0]     m_dat_o,
  output logic [1:0]        m_ack_o,
  output logic [1:0]        m_err_o,
  output logic [1:0]        m_rty_o,
  output logic [aw-1:0]     s_adr_o,
  output logic [1:0]        s_bte_o,
  output logic [2:0]        s_cti_o,
  output logic [3:0]        s_sel_o,
  output logic [dw-1:0]     s_dat_o,
  output logic              s_we_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [dw-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  localparam logic [7:0] lp_timeout = 8'(timeout);

  state_t     r_state;
  logic       r_last;
  logic [7:0] r_cnt;

  logic w_gnt0, w_gnt1, w_win;
  logic w_own_cyc, w_own_stb, w_resp, w_timeout;

  assign w_gnt0 = (r_state == GNT0);
  assign w_gnt1 = (r_state == GNT1);

  // On a tie the master that was not served last wins.
  assign w_win  = (&m_cyc_i) ? ~r_last : m_cyc_i[1];

  assign w_own_cyc = w_gnt1 ? m_cyc_i[1] : m_cyc_i[0];
  assign w_own_stb = w_gnt1 ? m_stb_i[1] : m_stb_i[0];
  assign w_resp    = s_ack_i | s_err_i | s_rty_i;

  // A genuine slave response in the same cycle beats the watchdog.
  assign w_timeout = (lp_timeout != 8'd0) && (w_gnt0 || w_gnt1) && w_own_cyc &&
                     w_own_stb && (r_cnt == lp_timeout) && !w_resp;

  assign s_cyc_o = (w_gnt0 || w_gnt1) && w_own_cyc;
  assign s_stb_o = s_cyc_o && w_own_stb && !w_timeout;

  assign s_adr_o = w_gnt1 ? m_adr_i[2*aw-1:aw] : m_adr_i[aw-1:0];
  assign s_bte_o = w_gnt1 ? m_bte_i[3:2]       : m_bte_i[1:0];
  assign s_cti_o = w_gnt1 ? m_cti_i[5:3]       : m_cti_i[2:0];
  assign s_sel_o = w_gnt1 ? m_sel_i[7:4]       : m_sel_i[3:0];
  assign s_dat_o = w_gnt1 ? m_dat_i[2*dw-1:dw] : m_dat_i[dw-1:0];
  assign s_we_o  = w_gnt1 ? m_we_i[1]          : m_we_i[0];

  assign m_dat_o = s_dat_i;
  assign m_ack_o = {w_gnt1 & s_ack_i, w_gnt0 & s_ack_i};
  assign m_err_o = {w_gnt1 & (s_err_i | w_timeout), w_gnt0 & (s_err_i | w_timeout)};
  assign m_rty_o = {w_gnt1 & s_rty_i, w_gnt0 & s_rty_i};

  // NOTE: the async reset clears every register here so the responses, which are
  // decoded from r_state, drop the instant rst_n falls -- no clock edge needed.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_cnt   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      case (r_state)
        IDLE: begin
          if (|m_cyc_i) begin
            r_state <= w_win ? GNT1 : GNT0;
            r_last  <= w_win;
          end
        end
        GNT0: begin
          if (!m_cyc_i[0]) begin
            if (m_cyc_i[1]) begin
              r_state <= GNT1;
              r_last  <= 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        GNT1: begin
          if (!m_cyc_i[1]) begin
            if (m_cyc_i[0]) begin
              r_state <= GNT0;
              r_last  <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase

      // A grant change always passes through an s_stb_o=0 cycle, so that
      // condition also covers clearing on a change of owner.
      if (w_resp || !s_stb_o) begin
        r_cnt <= 8'd0;
      end else if (r_cnt != 8'hFF) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_ram_arb2.sv
// Scenario bench for wb_ram_arb2: a zero-wait slave model acks strobes, and a
// scoreboard matches every ack against the transfer the masters issued.
`timescale 1ns/1ps
module tb_wb_ram_arb2;

  localparam int aw = 25;
  localparam int dw = 32;
  localparam int to = 4;

  logic              clk;
  logic              rst_n;
  logic [2*aw-1:0]   m_adr_i;
  logic [3:0]        m_bte_i;
  logic [5:0]        m_cti_i;
  logic [1:0]        m_cyc_i, m_stb_i, m_we_i;
  logic [7:0]        m_sel_i;
  logic [2*dw-1:0]   m_dat_i;
  logic [dw-1:0]     m_dat_o;
  logic [1:0]        m_ack_o, m_err_o, m_rty_o;
  logic [aw-1:0]     s_adr_o;
  logic [1:0]        s_bte_o;
  logic [2:0]        s_cti_o;
  logic [3:0]        s_sel_o;
  logic [dw-1:0]     s_dat_o;
  logic              s_we_o, s_cyc_o, s_stb_o;
  logic [dw-1:0]     s_dat_i;
  logic              s_ack_i, s_err_i, s_rty_i;

  typedef struct {
    logic          mst;
    logic [aw-1:0] adr;
    logic          we;
    logic [dw-1:0] dat;
  } exp_t;

  exp_t sb[$];
  int   total;
  int   bad;
  logic slave_en;
  logic slave_force;

  wb_ram_arb2 #(.aw(aw), .dw(dw), .timeout(to)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m_adr_i(m_adr_i), .m_bte_i(m_bte_i), .m_cti_i(m_cti_i), .m_cyc_i(m_cyc_i),
    .m_stb_i(m_stb_i), .m_we_i(m_we_i), .m_sel_i(m_sel_i), .m_dat_i(m_dat_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_bte_o(s_bte_o), .s_cti_o(s_cti_o), .s_sel_o(s_sel_o),
    .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [dw-1:0] rd_model(input logic [aw-1:0] a);
    return dw'(a) ^ 32'hA5A5_0000;
  endfunction

  task automatic set_m(input int n, input logic cyc, input logic stb, input logic we,
                       input logic [2:0] cti, input logic [aw-1:0] adr,
                       input logic [dw-1:0] dat);
    m_cyc_i[n]           = cyc;
    m_stb_i[n]           = stb;
    m_we_i[n]            = we;
    m_cti_i[n*3 +: 3]    = cti;
    m_bte_i[n*2 +: 2]    = 2'b00;
    m_sel_i[n*4 +: 4]    = 4'hF;
    m_adr_i[n*aw +: aw]  = adr;
    m_dat_i[n*dw +: dw]  = dat;
  endtask

  task automatic push_exp(input logic mst, input logic [aw-1:0] adr, input logic we,
                          input logic [dw-1:0] dat);
    exp_t e;
    e.mst = mst; e.adr = adr; e.we = we; e.dat = dat;
    sb.push_back(e);
  endtask

  // Slave model: zero-wait ack of any strobe while enabled, read data derived from address.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      s_ack_i = slave_force | (slave_en & s_cyc_o & s_stb_o);
      s_dat_i = rd_model(s_adr_o);
    end
  end

  // Scoreboard monitor, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (m_ack_o != 2'b00) begin
        total++;
        if (m_ack_o == 2'b11) begin
          bad++;
          $display("FAIL ack_both: m_ack_o=%b want one-hot", m_ack_o);
        end else if (sb.size() == 0) begin
          bad++;
          $display("FAIL ack_unexpected: m_ack_o=%b adr=%h want no ack", m_ack_o, s_adr_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (m_ack_o !== (e.mst ? 2'b10 : 2'b01) || s_adr_o !== e.adr || s_we_o !== e.we ||
              (e.we && s_dat_o !== e.dat) || (!e.we && m_dat_o !== e.dat)) begin
            bad++;
            $display("FAIL ack_data: ack=%b adr=%h we=%b sdat=%h mdat=%h want m%0d adr=%h we=%b dat=%h",
                     m_ack_o, s_adr_o, s_we_o, s_dat_o, m_dat_o, e.mst, e.adr, e.we, e.dat);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    slave_en = 1'b0; slave_force = 1'b0;
    s_err_i = 1'b0; s_rty_i = 1'b0; s_ack_i = 1'b0; s_dat_i = '0;
    set_m(0, 1'b1, 1'b1, 1'b0, 3'b000, 25'h0, 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 3'b000, 25'h0, 32'h0);
    @(negedge clk); #3;
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL rst_cyc: got %b want 0", s_cyc_o); end
    total++;
    if (s_stb_o !== 1'b0) begin bad++; $display("FAIL rst_stb: got %b want 0", s_stb_o); end
    total++;
    if ({m_ack_o, m_err_o, m_rty_o} !== 6'b0) begin
      bad++; $display("FAIL rst_resp: got %b want 000000", {m_ack_o, m_err_o, m_rty_o});
    end
  endtask

  task automatic test_tie();
    set_m(0, 1'b1, 1'b0, 1'b0, 3'b000, 25'h0_0100, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 3'b000, 25'h1_0200, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #3;
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL tie_idle: s_cyc_o=%b want 0", s_cyc_o); end
    @(negedge clk); #3;
    total++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 25'h0_0100) begin
      bad++; $display("FAIL tie_gnt0: cyc=%b adr=%h want 1 000100", s_cyc_o, s_adr_o);
    end
    @(negedge clk);
    m_cyc_i[0] = 1'b0;
    #3;
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL tie_gap: s_cyc_o=%b want 0", s_cyc_o); end
    @(negedge clk); #3;
    total++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 25'h1_0200) begin
      bad++; $display("FAIL tie_gnt1: cyc=%b adr=%h want 1 010200", s_cyc_o, s_adr_o);
    end
    @(negedge clk);
    m_cyc_i[1] = 1'b0;
    #3;
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL tie_end: s_cyc_o=%b want 0", s_cyc_o); end
  endtask

  task automatic test_burst();
    logic [2:0] cti;
    logic [aw-1:0] a;
    slave_en = 1'b1;
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 1'b1, 3'b010, 25'h0_1000, 32'hD000_0000);
    set_m(1, 1'b1, 1'b1, 1'b0, 3'b000, 25'h1_2000, 32'h0);
    #3;
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL burst_lat: s_cyc_o=%b want 0", s_cyc_o); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cti = (i == 3) ? 3'b111 : 3'b010;
      a   = 25'h0_1000 + 25'(4 * i);
      set_m(0, 1'b1, 1'b1, 1'b1, cti, a, 32'hD000_0000 + 32'(i));
      push_exp(1'b0, a, 1'b1, 32'hD000_0000 + 32'(i));
      #3;
      total++;
      if (s_adr_o !== a || s_cti_o !== cti || m_ack_o[1] !== 1'b0) begin
        bad++; $display("FAIL burst_beat%0d: adr=%h cti=%b ack=%b want adr=%h cti=%b m1 idle",
                        i, s_adr_o, s_cti_o, m_ack_o, a, cti);
      end
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 1'b0, 3'b000, 25'h0, 32'h0);
    #3;
    total++;
    if (s_cyc_o !== 1'b0 || m_ack_o !== 2'b00) begin
      bad++; $display("FAIL burst_gap: cyc=%b ack=%b want 0 00", s_cyc_o, m_ack_o);
    end
    @(negedge clk);
    push_exp(1'b1, 25'h1_2000, 1'b0, rd_model(25'h1_2000));
    #3;
    total++;
    if (s_adr_o !== 25'h1_2000 || s_cyc_o !== 1'b1) begin
      bad++; $display("FAIL burst_m1: adr=%h cyc=%b want 012000 1", s_adr_o, s_cyc_o);
    end
    @(negedge clk);
    set_m(1, 1'b0, 1'b0, 1'b0, 3'b000, 25'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [aw-1:0] base [2];
    logic [aw-1:0] a;
    int g;
    base[0] = 25'h0_3000;
    base[1] = 25'h1_3000;
    slave_en = 1'b1;
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 1'b0, 3'b000, base[0], 32'h0);
    set_m(1, 1'b1, 1'b1, 1'b0, 3'b000, base[1] + 25'd16, 32'h0);
    #3;
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL b2b_idle: s_cyc_o=%b want 0", s_cyc_o); end
    for (int t = 0; t < 4; t++) begin
      g = t % 2;
      a = base[g] + 25'(16 * t);
      @(negedge clk);
      set_m(g, 1'b1, 1'b1, 1'b0, 3'b000, a, 32'h0);
      set_m(1 - g, 1'b1, 1'b1, 1'b0, 3'b000, base[1-g] + 25'(16 * (t + 1)), 32'h0);
      push_exp(g[0], a, 1'b0, rd_model(a));
      #3;
      total++;
      if (s_cyc_o !== 1'b1 || s_adr_o !== a) begin
        bad++; $display("FAIL b2b_gnt%0d: cyc=%b adr=%h want 1 %h", t, s_cyc_o, s_adr_o, a);
      end
      @(negedge clk);
      set_m(g, 1'b0, 1'b0, 1'b0, 3'b000, 25'h0, 32'h0);
      if (t == 3) set_m(1 - g, 1'b0, 1'b0, 1'b0, 3'b000, 25'h0, 32'h0);
      #3;
      total++;
      if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL b2b_gap%0d: s_cyc_o=%b want 0", t, s_cyc_o); end
    end
  endtask

  task automatic test_timeout();
    logic [1:0] exp_err;
    logic       exp_stb;
    slave_en = 1'b0;
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 1'b0, 3'b000, 25'h0_4000, 32'h0);
    #3;
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL to_idle: s_cyc_o=%b want 0", s_cyc_o); end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 10) begin
        slave_force = 1'b1;
        push_exp(1'b0, 25'h0_4000, 1'b0, rd_model(25'h0_4000));
      end
      #3;
      exp_err = (c == 5) ? 2'b01 : 2'b00;
      exp_stb = (c != 5);
      total++;
      if (m_err_o !== exp_err || s_stb_o !== exp_stb) begin
        bad++; $display("FAIL to_cycle%0d: err=%b stb=%b want %b %b", c, m_err_o, s_stb_o, exp_err, exp_stb);
      end
    end
    @(negedge clk);
    slave_force = 1'b0;
    set_m(0, 1'b0, 1'b0, 1'b0, 3'b000, 25'h0, 32'h0);
    #3;
    total++;
    if (s_cyc_o !== 1'b0 || m_err_o !== 2'b00) begin
      bad++; $display("FAIL to_release: cyc=%b err=%b want 0 00", s_cyc_o, m_err_o);
    end
  endtask

  task automatic test_reset_midburst();
    slave_en = 1'b1;
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 1'b0, 3'b010, 25'h0_5000, 32'h0);
    #3;
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL mid_idle: s_cyc_o=%b want 0", s_cyc_o); end
    @(negedge clk);
    push_exp(1'b0, 25'h0_5000, 1'b0, rd_model(25'h0_5000));
    #3;
    total++;
    if (s_stb_o !== 1'b1) begin bad++; $display("FAIL mid_beat1: s_stb_o=%b want 1", s_stb_o); end
    @(negedge clk);
    slave_en = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, 3'b010, 25'h0_5004, 32'h0);
    set_m(1, 1'b1, 1'b0, 1'b0, 3'b000, 25'h1_5000, 32'h0);
    #3;
    total++;
    if (s_stb_o !== 1'b1 || s_adr_o !== 25'h0_5004) begin
      bad++; $display("FAIL mid_beat2: stb=%b adr=%h want 1 005004", s_stb_o, s_adr_o);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o} !== 8'b0) begin
      bad++; $display("FAIL mid_async: got %b want 00000000",
                      {s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o});
    end
    #4;
    rst_n = 1'b1;
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 1'b0, 3'b000, 25'h0_6000, 32'h0);
    #3;
    total++;
    if (s_cyc_o !== 1'b0) begin bad++; $display("FAIL mid_post_idle: s_cyc_o=%b want 0", s_cyc_o); end
    @(negedge clk); #3;
    total++;
    if (s_cyc_o !== 1'b1 || s_adr_o !== 25'h0_6000) begin
      bad++; $display("FAIL mid_m0_wins: cyc=%b adr=%h want 1 006000", s_cyc_o, s_adr_o);
    end
    @(negedge clk);
    set_m(0, 1'b0, 1'b0, 1'b0, 3'b000, 25'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 1'b0, 3'b000, 25'h0, 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_tie();
    test_burst();
    test_back_to_back();
    test_timeout();
    test_reset_midburst();
    @(negedge clk); #3;
    total++;
    if (sb.size() != 0) begin
      bad++; $display("FAIL sb_drain: pending=%0d want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_ram_arb2.md
WB_RAM_ARB2 -- requirements
Module: wb_ram_arb2

Interface
REQ-001 The block SHALL have parameter aw, default 25: Wishbone address width.
REQ-002 The block SHALL have parameter dw, default 32: Wishbone data width.
REQ-003 The block SHALL have parameter timeout, default 255 (range 0..255): no-response cycle limit; 0 disables the watchdog.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-005 wb_clk_i  in  1  clock.
REQ-006 wb_rst_n_i  in  1  asynchronous active-low reset.
REQ-007 m_adr_i  in  2*aw  master addresses, m0 in [aw-1:0], m1 in upper half.
REQ-008 m_bte_i  in  4  burst type extension, 2 bits per master.
REQ-009 m_cti_i  in  6  cycle type identifier, 3 bits per master.
REQ-010 m_cyc_i  in  2  cycle request, bit n = master n.
REQ-011 m_stb_i  in  2  strobe per master.
REQ-012 m_we_i  in  2  write enable per master.
REQ-013 m_sel_i  in  8  byte selects, 4 bits per master.
REQ-014 m_dat_i  in  2*dw  write data per master.
REQ-015 m_dat_o  out  dw  read data, driven from s_dat_i to both masters.
REQ-016 m_ack_o / m_err_o / m_rty_o  out  2 each  per-master responses.
REQ-017 s_adr_o, s_bte_o, s_cti_o, s_sel_o, s_dat_o, s_we_o  out  aw/2/3/4/dw/1  muxed slave request fields.
REQ-018 s_cyc_o, s_stb_o  out  1 each  slave cycle and strobe.
REQ-019 s_dat_i, s_ack_i, s_err_i, s_rty_i  in  dw/1/1/1  slave read data and responses.

Function
REQ-020 The arbiter SHALL be a registered FSM with states IDLE, GNT0 and GNT1, where grant selects which master drives all s_* request outputs.
REQ-021 In IDLE, s_cyc_o and s_stb_o SHALL be 0, and all m_ack_o, m_err_o and m_rty_o bits SHALL be 0.
REQ-022 In IDLE with any m_cyc_i set, the FSM SHALL move to GNT of the round-robin winner at the next edge, giving one cycle of arbitration latency.
REQ-023 The round-robin winner SHALL be the master not served last; the last-served pointer SHALL reset to 1 so that m0 wins the first tie.
REQ-024 While in GNTn, s_cyc_o SHALL equal m_cyc_i[n], and s_stb_o SHALL equal m_stb_i[n] & m_cyc_i[n] except when forced by REQ-029.
REQ-025 While in GNTn, m_ack_o[n], m_err_o[n] and m_rty_o[n] SHALL pass through combinationally from the slave, and the other master's response bits SHALL be 0.
REQ-026 A grant SHALL be held, including across B3 bursts (cti 001/010 through 111), for as long as m_cyc_i[n] is 1; the other master SHALL never preempt it.
REQ-027 Release: when m_cyc_i[n] is 0 at an edge, the FSM SHALL go to GNT of the other master if that master's cyc is 1, otherwise to IDLE; this guarantees at least one s_cyc_o=0 cycle between owners.
REQ-028 Watchdog:
- an 8-bit counter SHALL clear on grant change, on s_ack_i|s_err_i|s_rty_i, or when s_stb_o=0;
- otherwise it SHALL increment while s_cyc_o&s_stb_o;
- it SHALL never wrap.
REQ-029 When the counter equals timeout (timeout != 0), the block SHALL for that one cycle:
- assert m_err_o[n]=1;
- force s_stb_o=0;
- clear the counter.
The grant SHALL be kept until the master drops cyc.
REQ-030 Simultaneous events: a new request arriving in the same cycle as a release SHALL be handled per REQ-027; a slave response in the same cycle as a timeout SHALL win, and no timeout error SHALL be raised in that cycle.

Reset
REQ-031 While wb_rst_n_i is 0, the block SHALL immediately and asynchronously set the state to IDLE, the last-served pointer to 1 and the counter to 0, so that s_cyc_o, s_stb_o and all m_*_o responses are 0.
REQ-032 Reset asserted mid-burst SHALL abort the grant with no further response to the master; deassertion SHALL take effect at the next clock edge.

Verification
REQ-033 Reset, then m_cyc_i=11 at the same edge -> GNT0 one cycle later; on m0 release, GNT1 follows after exactly one s_cyc_o=0 cycle.
REQ-034 m0 issues a 4-beat incrementing burst (cti 010,010,010,111; bte 00) while m1 requests -> all four acks are routed to m0 only, and m1 is granted only after m0's cyc drops.
REQ-035 Alternating back-to-back single classic transfers from both masters -> grants alternate 0,1,0,1, and m_ack_o never has both bits set.
REQ-036 With timeout=4, the slave never responds -> m_err_o[n]=1 for exactly one cycle on the 5th cycle of strobing; s_stb_o=0 in that cycle.
REQ-037 wb_rst_n_i is pulsed low for half a clock during the 2nd beat of a burst -> outputs go to 0 without waiting for a clock edge; after release the FSM is in IDLE and the next request from m0 wins.
